sc_s2b_et: RTL and testbench
============================

# sc_s2b_et

Stochastic-to-binary converter with early-termination support, the receiving end of the counter-based SNG (CAPE-family) generators. It counts ones on NUM_INPUTS parallel bitstreams over one stream period and terminates the period on an upstream last/done marker or at the full 2^WIDTH length. It normalizes each count back to a WIDTH-bit binary value and presents the result on a valid/ready output port. It sits downstream of the SC compute datapath and feeds binary results back to the host/accumulation logic.

## Interface
- WIDTH, 8: binary precision; full stream length is 2^WIDTH cycles.
- NUM_INPUTS, 4: number of parallel bitstreams.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  Xs carries one stream bit per lane this cycle.
- in_ready  out  1  converter accepts a bit this cycle.
- Xs  in  NUM_INPUTS  stream bits, lane i = Xs[i].
- in_last  in  1  the bit presented with in_valid is the final bit of the period (early termination / generator done).
- out_valid  out  1  result registers hold a completed period.
- out_ready  in  1  consumer takes the result.
- Bxs_out  out  WIDTH*NUM_INPUTS  normalized results, lane i at [i*WIDTH +: WIDTH].
- out_len  out  WIDTH+1  number of bits accepted in the period (1..2^WIDTH).
- len_pow2  out  1  out_len is a power of two, so Bxs_out is scaled.
- overrun  out  1  sticky: a bit was presented while in_ready=0.

## Operation
- The block is a single clock domain. rst is synchronous and active-high.
- State machine: IDLE, ACCUM, HOLD.
  - IDLE: len=0, all ones-counters=0. An accepted bit moves to ACCUM, or to HOLD if the bit is last.
  - ACCUM: each accepted bit adds Xs[i] to counter i (WIDTH+1 bits) and increments len (WIDTH+1 bits).
  - HOLD: out_valid=1 and all results are frozen. When out_valid & out_ready, counters and len clear and the state moves to IDLE.
- Acceptance: a bit is accepted on (in_valid & in_ready). in_ready=1 in IDLE and ACCUM, and 0 in HOLD.
- Termination condition: an accepted bit with in_last=1, or an accepted bit that makes len reach 2^WIDTH (auto-terminate, in_last not required). The terminating bit is included in the counts.
- Normalization at termination, computed on the final count values and registered on entry to HOLD:
  - If len=2^k (0≤k≤WIDTH): Bxs_out[i] = ones[i] << (WIDTH-k), saturated to 2^WIDTH-1. len_pow2=1.
  - Otherwise: Bxs_out[i] = ones[i], saturated to 2^WIDTH-1, unshifted. len_pow2=0.
- overrun sets when in_valid=1 and in_ready=0. It is cleared only by rst. The bit presented in that cycle is dropped and does not affect counters.
- in_last with in_valid=0 is ignored.

## Timing
- Reset values: out_valid=0, in_ready=1 (state IDLE), Bxs_out=0, out_len=0, len_pow2=0, overrun=0. Counters and len are 0.
- Result latency: if the terminating bit is accepted at edge t, then out_valid=1 and the final Bxs_out, out_len and len_pow2 are visible after edge t (one-cycle registered latency).
- Results stay stable for the whole HOLD period, whatever out_ready does.
- Handshake completing at edge t2: out_valid=0 and in_ready=1 after t2. Between consecutive periods there is a one-cycle minimum bubble: in_ready is 0 during the handshake cycle itself.
- Reset mid-period or during HOLD: all state and outputs return to reset values at that edge. Partial counts are discarded. A pending result is lost without a handshake.
- Counter width: WIDTH+1 bits, so no counter ever wraps; len never exceeds 2^WIDTH.
- Single-bit period (in_last on the first bit): len=1=2^0, so Bxs_out[i] = Xs[i] << WIDTH, saturated to 2^WIDTH-1 when Xs[i]=1.

## Test plan
- WIDTH=8, NUM_INPUTS=2, full period: 256 bits from a CAPE-style comparator with Bx={64,200}, in_last on bit 255 -> out_valid one cycle later; Bxs_out={64,200}, out_len=256, len_pow2=1.
- Early termination at 16 bits: lane0 has 4 ones, lane1 has 16 ones, in_last on bit 15 -> Bxs_out={64,255} (lane1 saturates from 256), out_len=16, len_pow2=1.
- Auto-terminate: 256 valid bits with in_last never asserted, lane0 all zeros -> out_valid after bit 255; Bxs_out lane0=0, out_len=256.
- Non-power-of-two length: 12 bits, lane0 has 6 ones, in_last on bit 11 -> Bxs_out lane0=6, out_len=12, len_pow2=0.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD while pulsing in_valid -> in_ready=0, overrun=1, results unchanged. Then raise out_ready for one cycle -> out_valid=0 and in_ready=1 next cycle; overrun stays 1.
- Reset mid-period: assert rst after 100 accepted bits, then run a fresh 16-bit period with 8 ones in lane0 -> Bxs_out lane0=128, out_len=16. No carry-over from the aborted period.

Source files
------------

// File: rtl/sc_s2b_et.sv
// Stochastic-to-binary converter: counts ones per lane over a stream period that ends on
// in_last or at 2^WIDTH accepted bits, then holds the normalized result on a valid/ready port.
module sc_s2b_et #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_INPUTS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_INPUTS-1:0]       Xs,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH*NUM_INPUTS-1:0] Bxs_out,
   output logic [WIDTH:0]              out_len,
   output logic                        len_pow2,
   output logic                        overrun
);

   localparam int unsigned CW = WIDTH + 1;
   localparam int unsigned SW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FullLen = {1'b1, {WIDTH{1'b0}}};
   localparam logic [CW-1:0] OneLen  = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e                           r_state, w_state_next;
   logic [CW-1:0]                    r_len, w_len_next, w_len_inc;
   logic [NUM_INPUTS-1:0][CW-1:0]    r_ones, w_ones_next, w_ones_inc, w_shifted;
   logic [NUM_INPUTS-1:0][WIDTH-1:0] r_bxs, w_bxs_next, w_norm;
   logic [CW-1:0]                    r_out_len, w_out_len_next;
   logic                             r_pow2, w_pow2_next;
   logic                             r_overrun;
   logic                             w_accept, w_term, w_is_pow2;
   logic [SW-1:0]                    w_shamt;

   assign in_ready  = (r_state != StHold);
   assign out_valid = (r_state == StHold);
   assign w_accept  = in_valid & in_ready;
   assign w_len_inc = r_len + OneLen;
   assign w_term    = in_last | (w_len_inc == FullLen);

   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_ones_inc[i] = r_ones[i] + {{WIDTH{1'b0}}, Xs[i]};
      end
   end

   // A power-of-two length 2^k rescales by 2^(WIDTH-k); other lengths pass through unshifted.
   always_comb begin
      w_is_pow2 = 1'b0;
      w_shamt   = '0;
      for (int k = 0; k <= WIDTH; k++) begin
         if (w_len_inc == (OneLen << k)) begin
            w_is_pow2 = 1'b1;
            w_shamt   = SW'(WIDTH - k);
         end
      end
   end

   // ones <= len, so the shifted value never exceeds 2^WIDTH; only that one value saturates.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_shifted[i] = w_ones_inc[i] << w_shamt;
         w_norm[i]    = w_shifted[i][WIDTH] ? {WIDTH{1'b1}} : w_shifted[i][WIDTH-1:0];
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_len_next     = r_len;
      w_ones_next    = r_ones;
      w_bxs_next     = r_bxs;
      w_out_len_next = r_out_len;
      w_pow2_next    = r_pow2;
      unique case (r_state)
         StIdle, StAccum: begin
            if (w_accept) begin
               w_len_next  = w_len_inc;
               w_ones_next = w_ones_inc;
               if (w_term) begin
                  w_state_next   = StHold;
                  w_bxs_next     = w_norm;
                  w_out_len_next = w_len_inc;
                  w_pow2_next    = w_is_pow2;
               end else begin
                  w_state_next = StAccum;
               end
            end
         end
         StHold: begin
            if (out_ready) begin
               w_state_next = StIdle;
               w_len_next   = '0;
               w_ones_next  = '0;
            end
         end
         default: begin
            w_state_next = StIdle;
            w_len_next   = '0;
            w_ones_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_len     <= '0;
         r_ones    <= '0;
         r_bxs     <= '0;
         r_out_len <= '0;
         r_pow2    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_len     <= w_len_next;
         r_ones    <= w_ones_next;
         r_bxs     <= w_bxs_next;
         r_out_len <= w_out_len_next;
         r_pow2    <= w_pow2_next;
         r_overrun <= r_overrun | (in_valid & ~in_ready);
      end
   end

   assign Bxs_out  = r_bxs;
   assign out_len  = r_out_len;
   assign len_pow2 = r_pow2;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_sc_s2b_et.sv
// Scoreboard bench for sc_s2b_et (WIDTH=8, two lanes): a bit-level model predicts each period's
// result when its terminating bit is driven; a negedge monitor compares every HOLD cycle.
module tb_sc_s2b_et;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NIN   = 2;

   typedef struct {
      logic [15:0] bxs;
      logic [8:0]  len;
      logic        pow2;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NIN-1:0]    Xs = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [15:0]       Bxs_out;
   logic [8:0]        out_len;
   logic              len_pow2;
   logic              overrun;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_len    = 0;
   int   m_ones0  = 0;
   int   m_ones1  = 0;
   exp_t sb_q[$];
   exp_t cur;
   logic have = 1'b0;

   sc_s2b_et #(.WIDTH(WIDTH), .NUM_INPUTS(NIN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xs        (Xs),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Bxs_out   (Bxs_out),
      .out_len   (out_len),
      .len_pow2  (len_pow2),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] norm(input int ones, input int len);
      int v;
      v = ones;
      for (int k = 0; k <= 8; k++) begin
         if (len == (1 << k)) v = ones << (8 - k);
      end
      if (v > 255) v = 255;
      return 8'(v);
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] c);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = c[7-b];
      return r;
   endfunction

   task automatic send_bit(input logic [1:0] x, input logic last);
      exp_t e;
      if (m_len == 0) check("in_ready_start", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      Xs       = x;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      Xs       = '0;
      m_len++;
      m_ones0 += int'(x[0]);
      m_ones1 += int'(x[1]);
      if (last || m_len == 256) begin
         e.bxs  = {norm(m_ones1, m_len), norm(m_ones0, m_len)};
         e.len  = 9'(m_len);
         e.pow2 = ((m_len & (m_len - 1)) == 0);
         sb_q.push_back(e);
         check("latency_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         m_len   = 0;
         m_ones0 = 0;
         m_ones1 = 0;
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      #1;
      check("hs_cycle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_out_valid_low", 32'(out_valid), 32'd0);
      check("hs_in_ready_high", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_bxs"}, 32'(Bxs_out), 32'd0);
      check({tag, "_out_len"}, 32'(out_len), 32'd0);
      check({tag, "_len_pow2"}, 32'(len_pow2), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   // Results must match the prediction on every cycle of HOLD.
   always @(negedge clk) begin
      if (out_valid) begin
         if (!have) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               cur  = sb_q.pop_front();
               have = 1'b1;
            end
         end
         if (have) begin
            check("bxs_out", 32'(Bxs_out), 32'(cur.bxs));
            check("out_len", 32'(out_len), 32'(cur.len));
            check("len_pow2", 32'(len_pow2), 32'(cur.pow2));
         end
      end else begin
         have = 1'b0;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset");

      // Full period from a bit-reversed-counter comparator, Bx = {64, 200}.
      for (int j = 0; j < 256; j++) begin
         logic [7:0] r;
         r = rev8(8'(j));
         send_bit({r < 8'd200, r < 8'd64}, j == 255);
      end
      take_result();

      // Early termination at 16 bits; lane1 saturates.
      for (int j = 0; j < 16; j++) send_bit({1'b1, j < 4}, j == 15);
      take_result();

      // Auto-terminate with in_last never asserted.
      for (int j = 0; j < 256; j++) send_bit({(j % 3) == 0, 1'b0}, 1'b0);
      take_result();

      // Single-bit period.
      send_bit(2'b01, 1'b1);
      take_result();

      // Non-power-of-two length, then backpressure while the result is held.
      for (int j = 0; j < 12; j++) send_bit({j < 11, (j % 2) == 0}, j == 11);
      check("overrun_clear", 32'(overrun), 32'd0);
      for (int c = 0; c < 10; c++) begin
         in_valid = ((c % 2) == 0);
         Xs       = 2'b11;
         in_last  = 1'b1;
         @(posedge clk);
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      Xs       = '0;
      check("overrun_set", 32'(overrun), 32'd1);
      take_result();
      check("overrun_sticky", 32'(overrun), 32'd1);

      // Abort a period with reset after 100 bits; nothing may carry over.
      for (int j = 0; j < 100; j++) send_bit(2'($urandom_range(0, 3)), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_len   = 0;
      m_ones0 = 0;
      m_ones1 = 0;
      check_reset_state("midreset");
      for (int j = 0; j < 16; j++) send_bit({1'($urandom_range(0, 1)), (j % 2) == 1}, j == 15);
      take_result();

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
